// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath slice.
//   DATA_W      : architectural register width (8 bits)
//   NUM_OPS     : number of controller operation enables
//   alu_op_e    : 4-bit op code, 0x0 ADD through 0xF LOAD, matching the
//                 controller's operation codes and the enable bit order
//   state_e     : sequencing states of the datapath controller
//   alu_flags_t : status flags produced by the combinational core
//   helpers     : one-hot test, op-enable encoder, command legality check
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_OPS = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_SHL  = 4'h2,
        OP_SHR  = 4'h3,
        OP_CMP  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NAND = 4'h8,
        OP_NOR  = 4'h9,
        OP_XNOR = 4'hA,
        OP_NOT  = 4'hB,
        OP_NEG  = 4'hC,
        OP_STO  = 4'hD,
        OP_SWP  = 4'hE,
        OP_LOAD = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

    // Ops ADD..NEG occupy the low codes and are the only ones that write Y.
    function automatic logic op_writes_y(input alu_op_e op);
        return (op <= OP_NEG);
    endfunction

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_one_hot(input logic [NUM_OPS-1:0] v);
        logic [NUM_OPS-1:0] one;
        one = {{(NUM_OPS-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    // Lowest set enable wins; only meaningful when the vector is one-hot.
    function automatic alu_op_e encode_op(input logic [NUM_OPS-1:0] op_en);
        alu_op_e op;
        op = OP_ADD;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (op_en[i]) begin
                op = alu_op_e'(i[3:0]);
            end
        end
        return op;
    endfunction

    // A command is legal when one op is requested and the register-write
    // qualifiers match the destination(s) that op actually writes.
    function automatic logic command_legal(input logic [NUM_OPS-1:0] op_en,
                                           input logic en_a,
                                           input logic en_b,
                                           input logic en_y);
        logic ok;
        ok = 1'b0;
        if (is_one_hot(op_en)) begin
            case (encode_op(op_en))
                OP_STO, OP_LOAD: ok = en_a & ~en_b & ~en_y;
                OP_SWP:          ok = en_a &  en_b & ~en_y;
                default:         ok = ~en_a & ~en_b & en_y;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational result and flag generator.
//   op    : decoded operation (alu_op_e)
//   a, b  : operands, 8-bit unsigned
//   y     : result (zero for ops that do not write Y)
//   flags : zero/neg from y; carry and ovf per operation
module alu_core
    import alu_pkg::*;
(
    input  alu_op_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   y,
    output alu_flags_t          flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] wide;
    logic            carry;
    logic            ovf;

    // Result, carry and overflow selection. Arithmetic uses a one-bit wider
    // sum so the top bit is carry-out for ADD and borrow for SUB.
    always_comb begin
        wide  = '0;
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                y     = wide[MSB:0];
                carry = wide[DATA_W];
                ovf   = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                y     = wide[MSB:0];
                carry = wide[DATA_W];
                ovf   = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
            end
            OP_SHL: begin
                y     = {a[MSB-1:0], 1'b0};
                carry = a[MSB];
            end
            OP_SHR: begin
                y     = {1'b0, a[MSB:1]};
                carry = a[0];
            end
            OP_CMP: begin
                if (a > b) begin
                    y = {{(DATA_W-1){1'b0}}, 1'b1};
                end else if (a == b) begin
                    y = '0;
                end else begin
                    y = '1;
                end
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_NEG: begin
                y     = '0 - a;
                carry = |a;
                // Only the most negative value negates to itself.
                ovf   = a[MSB] & y[MSB];
            end
            default: begin
                y = '0;
            end
        endcase
    end

    // Flags derived from the chosen result.
    always_comb begin
        flags.zero  = (y == '0);
        flags.neg   = y[MSB];
        flags.carry = carry;
        flags.ovf   = ovf;
    end

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath
// Architectural registers A, B, Y plus status flags, sequenced by a small
// IDLE/EXEC/HOLD controller so that a held button executes exactly once.
//   clk, reset_n        : clock; synchronous active-low reset
//   sw_data             : switch operand written to A by LOAD
//   enable_A/B/Y        : register-write qualifiers from the controller
//   enable_<op>         : per-operation enables (nominally one-hot)
//   reg_a, reg_b, reg_y : architectural registers
//   flag_*              : status of the last Y-writing op
//   done                : one-cycle pulse, coincident with the new values
//   err                 : sticky illegal-command indicator
module alu_datapath
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              enable_A,
    input  logic              enable_B,
    input  logic              enable_Y,
    input  logic              enable_add,
    input  logic              enable_sub,
    input  logic              enable_shl,
    input  logic              enable_shr,
    input  logic              enable_cmp,
    input  logic              enable_and,
    input  logic              enable_or,
    input  logic              enable_xor,
    input  logic              enable_nand,
    input  logic              enable_nor,
    input  logic              enable_xnor,
    input  logic              enable_not,
    input  logic              enable_neg,
    input  logic              enable_sto,
    input  logic              enable_swp,
    input  logic              enable_load,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] reg_y,
    output logic              flag_zero,
    output logic              flag_neg,
    output logic              flag_carry,
    output logic              flag_ovf,
    output logic              done,
    output logic              err
);

    // Enable vector ordered so that bit index equals the op code.
    logic [NUM_OPS-1:0] op_en;
    assign op_en = {enable_load, enable_swp, enable_sto, enable_neg,
                    enable_not,  enable_xnor, enable_nor, enable_nand,
                    enable_xor,  enable_or,  enable_and, enable_cmp,
                    enable_shr,  enable_shl, enable_sub, enable_add};

    logic    any_op;
    logic    cmd_ok;
    alu_op_e op_decoded;

    assign any_op     = |op_en;
    assign cmd_ok     = command_legal(op_en, enable_A, enable_B, enable_Y);
    assign op_decoded = encode_op(op_en);

    state_e  state;
    state_e  state_next;
    alu_op_e op_q;

    logic do_capture;
    logic do_exec;
    logic set_err;

    // Per-destination write strobes, active only on the EXEC edge.
    logic wr_y;
    logic wr_sto;
    logic wr_swp;
    logic wr_load;

    logic [DATA_W-1:0] core_y;
    alu_flags_t        core_flags;

    // Operands are the live registers: nothing writes them between capture
    // and execution, so the core sees the same values the op was issued on.
    alu_core u_core (
        .op    (op_q),
        .a     (reg_a),
        .b     (reg_b),
        .y     (core_y),
        .flags (core_flags)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control strobes. Illegal commands go straight to HOLD
    // so they are consumed (and flagged) without ever reaching EXEC.
    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        do_exec    = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_op) begin
                    do_capture = 1'b1;
                    if (cmd_ok) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_HOLD;
                        set_err    = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // Completes regardless of whether the enables are still held.
                do_exec    = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!any_op) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_y    = do_exec & op_writes_y(op_q);
    assign wr_sto  = do_exec & (op_q == OP_STO);
    assign wr_swp  = do_exec & (op_q == OP_SWP);
    assign wr_load = do_exec & (op_q == OP_LOAD);

    // Architectural registers, flags, done and err. done is registered from
    // the EXEC strobe so it rises together with the written values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q       <= OP_ADD;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_y      <= '0;
            flag_zero  <= 1'b0;
            flag_neg   <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= do_exec;

            if (do_capture) begin
                op_q <= op_decoded;
            end

            if (set_err) begin
                err <= 1'b1;
            end

            if (wr_y) begin
                reg_y      <= core_y;
                flag_zero  <= core_flags.zero;
                flag_neg   <= core_flags.neg;
                flag_carry <= core_flags.carry;
                flag_ovf   <= core_flags.ovf;
            end

            if (wr_load) begin
                reg_a <= sw_data;
            end else if (wr_sto) begin
                reg_a <= reg_y;
            end else if (wr_swp) begin
                reg_a <= reg_b;
            end

            if (wr_swp) begin
                reg_b <= reg_a;
            end
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath
// Directed and randomized stimulus for alu_datapath, checked against an
// integer-arithmetic reference model of the architectural state.
module tb_alu_datapath;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SHL  = 2;
    localparam int OP_SHR  = 3;
    localparam int OP_CMP  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_NAND = 8;
    localparam int OP_NOR  = 9;
    localparam int OP_XNOR = 10;
    localparam int OP_NOT  = 11;
    localparam int OP_NEG  = 12;
    localparam int OP_STO  = 13;
    localparam int OP_SWP  = 14;
    localparam int OP_LOAD = 15;

    // Write-qualifier patterns {A,B,Y}.
    localparam logic [2:0] EN_Y  = 3'b001;
    localparam logic [2:0] EN_A  = 3'b100;
    localparam logic [2:0] EN_AB = 3'b110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  sw_data;
    logic        enable_A, enable_B, enable_Y;
    logic [15:0] op_en;
    logic [7:0]  reg_a, reg_b, reg_y;
    logic        flag_zero, flag_neg, flag_carry, flag_ovf;
    logic        done, err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] m_a, m_b, m_y;
    logic       m_z, m_n, m_c, m_v, m_err;

    int done_pulses;
    int first_done;

    int          r_op;
    logic [15:0] r_mask;
    logic [2:0]  r_en;

    always #5 clk = ~clk;

    alu_datapath dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_data     (sw_data),
        .enable_A    (enable_A),
        .enable_B    (enable_B),
        .enable_Y    (enable_Y),
        .enable_add  (op_en[0]),
        .enable_sub  (op_en[1]),
        .enable_shl  (op_en[2]),
        .enable_shr  (op_en[3]),
        .enable_cmp  (op_en[4]),
        .enable_and  (op_en[5]),
        .enable_or   (op_en[6]),
        .enable_xor  (op_en[7]),
        .enable_nand (op_en[8]),
        .enable_nor  (op_en[9]),
        .enable_xnor (op_en[10]),
        .enable_not  (op_en[11]),
        .enable_neg  (op_en[12]),
        .enable_sto  (op_en[13]),
        .enable_swp  (op_en[14]),
        .enable_load (op_en[15]),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .reg_y       (reg_y),
        .flag_zero   (flag_zero),
        .flag_neg    (flag_neg),
        .flag_carry  (flag_carry),
        .flag_ovf    (flag_ovf),
        .done        (done),
        .err         (err)
    );

    // Single comparison point: counts, asserts, reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".reg_a"}, 32'(reg_a), 32'(m_a));
        checkOutput({tag, ".reg_b"}, 32'(reg_b), 32'(m_b));
        checkOutput({tag, ".reg_y"}, 32'(reg_y), 32'(m_y));
        checkOutput({tag, ".zero"},  32'(flag_zero),  32'(m_z));
        checkOutput({tag, ".neg"},   32'(flag_neg),   32'(m_n));
        checkOutput({tag, ".carry"}, 32'(flag_carry), 32'(m_c));
        checkOutput({tag, ".ovf"},   32'(flag_ovf),   32'(m_v));
        checkOutput({tag, ".err"},   32'(err),        32'(m_err));
    endtask

    function automatic bit model_legal(input logic [15:0] mask, input logic [2:0] en);
        int op;
        op = 0;
        if ($countones(mask) != 1) return 1'b0;
        for (int i = 0; i < 16; i++) if (mask[i]) op = i;
        if (op == OP_STO || op == OP_LOAD) return en == EN_A;
        if (op == OP_SWP) return en == EN_AB;
        return en == EN_Y;
    endfunction

    task automatic model_reset();
        m_a = 8'h00; m_b = 8'h00; m_y = 8'h00;
        m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0; m_err = 1'b0;
    endtask

    // Reference behaviour expressed as plain integer arithmetic.
    task automatic model_exec(input int op, input logic [7:0] sw);
        int a, b, sa, sb, r, sr;
        bit writes_y, c, v;
        a = int'(m_a);
        b = int'(m_b);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; sr = 0; c = 1'b0; v = 1'b0; writes_y = 1'b1;
        case (op)
            OP_ADD:  begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            OP_SUB:  begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
            OP_SHL:  begin r = a * 2; c = (a >= 128); end
            OP_SHR:  begin r = a / 2; c = (a % 2 == 1); end
            OP_CMP:  r = (a > b) ? 1 : ((a == b) ? 0 : 255);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = 255 - (a & b);
            OP_NOR:  r = 255 - (a | b);
            OP_XNOR: r = 255 - (a ^ b);
            OP_NOT:  r = 255 - a;
            OP_NEG:  begin r = -a; c = (a != 0); sr = -sa; v = (sr > 127); end
            OP_STO:  begin m_a = m_y; writes_y = 1'b0; end
            OP_SWP:  begin m_a = 8'(b); m_b = 8'(a); writes_y = 1'b0; end
            default: begin m_a = sw; writes_y = 1'b0; end
        endcase
        if (writes_y) begin
            r   = ((r % 256) + 256) % 256;
            m_y = 8'(r);
            m_z = (r == 0);
            m_n = (r >= 128);
            m_c = c;
            m_v = v;
        end
    endtask

    task automatic clearInputs();
        op_en = 16'h0000; enable_A = 1'b0; enable_B = 1'b0; enable_Y = 1'b0;
    endtask

    // Holds a command for 'hold' cycles, releases it, waits for HOLD->IDLE,
    // then compares the DUT against the model and the done-pulse count.
    task automatic applyStimulus(input string tag, input logic [15:0] mask,
                                 input logic [2:0] en, input logic [7:0] sw,
                                 input int hold);
        bit legal;
        int op;
        legal = model_legal(mask, en);
        op = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) op = i;
        @(negedge clk);
        op_en = mask;
        {enable_A, enable_B, enable_Y} = en;
        sw_data = sw;
        done_pulses = 0;
        first_done = 0;
        for (int cyc = 1; cyc <= hold + 2; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_pulses++;
                if (first_done == 0) first_done = cyc;
            end
            if (cyc == hold) clearInputs();
        end
        if (legal) model_exec(op, sw);
        else m_err = 1'b1;
        checkOutput({tag, ".done_count"}, 32'(done_pulses), legal ? 32'd1 : 32'd0);
        if (legal) checkOutput({tag, ".done_latency"}, 32'(first_done), 32'd2);
        checkState(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        checkState("reset");
        checkOutput("reset.done", 32'(done), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic randomCommand(input bit allow_illegal);
        r_op = int'($urandom_range(0, 15));
        r_mask = 16'h0001 << r_op;
        if (r_op == OP_STO || r_op == OP_LOAD) r_en = EN_A;
        else if (r_op == OP_SWP) r_en = EN_AB;
        else r_en = EN_Y;
        if (allow_illegal && ($urandom_range(0, 5) == 0)) begin
            if ($urandom_range(0, 1) == 1) r_mask = r_mask | (16'h0001 << $urandom_range(0, 15));
            else r_en = r_en ^ 3'(1 << $urandom_range(0, 2));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sw_data = 8'h00;
        clearInputs();
        model_reset();
        $display("[TB] start");

        doReset();

        // Single held LOAD executes once.
        applyStimulus("load2a", 16'h0001 << OP_LOAD, EN_A, 8'h2A, 5);
        checkOutput("load2a.a_const", 32'(reg_a), 32'h2A);

        // LOAD/SWP/LOAD/ADD then SUB.
        applyStimulus("load05", 16'h0001 << OP_LOAD, EN_A, 8'h05, 2);
        applyStimulus("swp1",   16'h0001 << OP_SWP,  EN_AB, 8'h00, 2);
        applyStimulus("load03", 16'h0001 << OP_LOAD, EN_A, 8'h03, 3);
        applyStimulus("add",    16'h0001 << OP_ADD,  EN_Y, 8'h00, 2);
        checkOutput("add.y_const", 32'(reg_y), 32'h08);
        checkOutput("add.b_const", 32'(reg_b), 32'h05);
        applyStimulus("sub",    16'h0001 << OP_SUB,  EN_Y, 8'h00, 2);
        checkOutput("sub.y_const", 32'(reg_y), 32'hFE);
        checkOutput("sub.c_const", 32'(flag_carry), 32'd1);

        // Long-held shift, then logical right shift.
        applyStimulus("load80", 16'h0001 << OP_LOAD, EN_A, 8'h80, 2);
        applyStimulus("shl",    16'h0001 << OP_SHL,  EN_Y, 8'h00, 10);
        checkOutput("shl.z_const", 32'(flag_zero), 32'd1);
        applyStimulus("shr",    16'h0001 << OP_SHR,  EN_Y, 8'h00, 1);
        checkOutput("shr.y_const", 32'(reg_y), 32'h40);

        // CMP, STO, NEG with A=0x03, B=0x05.
        applyStimulus("load05b", 16'h0001 << OP_LOAD, EN_A, 8'h05, 2);
        applyStimulus("swp2",    16'h0001 << OP_SWP,  EN_AB, 8'h00, 2);
        applyStimulus("load03b", 16'h0001 << OP_LOAD, EN_A, 8'h03, 2);
        applyStimulus("cmp",     16'h0001 << OP_CMP,  EN_Y, 8'h00, 2);
        checkOutput("cmp.y_const", 32'(reg_y), 32'hFF);
        applyStimulus("sto",     16'h0001 << OP_STO,  EN_A, 8'h00, 2);
        checkOutput("sto.a_const", 32'(reg_a), 32'hFF);
        applyStimulus("neg",     16'h0001 << OP_NEG,  EN_Y, 8'h00, 2);
        checkOutput("neg.y_const", 32'(reg_y), 32'h01);

        // Legal-only random commands, including one-cycle button presses.
        for (int k = 0; k < 40; k++) begin
            randomCommand(1'b0);
            applyStimulus("rand_legal", r_mask, r_en, 8'($urandom), int'($urandom_range(1, 4)));
        end

        // Two ops at once is rejected; a later legal op still runs.
        applyStimulus("illegal2", (16'h0001 << OP_ADD) | (16'h0001 << OP_SUB), EN_Y, 8'h00, 3);
        checkOutput("illegal2.err_const", 32'(err), 32'd1);
        applyStimulus("illegal_qual", 16'h0001 << OP_ADD, EN_A, 8'h00, 2);
        applyStimulus("add_after_err", 16'h0001 << OP_ADD, EN_Y, 8'h00, 2);

        for (int k = 0; k < 30; k++) begin
            randomCommand(1'b1);
            applyStimulus("rand_mix", r_mask, r_en, 8'($urandom), int'($urandom_range(1, 4)));
        end

        // Reset arriving while ADD sits in EXEC.
        applyStimulus("load11", 16'h0001 << OP_LOAD, EN_A, 8'h11, 2);
        @(negedge clk);
        op_en = 16'h0001 << OP_ADD;
        {enable_A, enable_B, enable_Y} = EN_Y;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        checkState("rst_exec");
        checkOutput("rst_exec.done", 32'(done), 32'd0);
        clearInputs();
        reset_n = 1'b1;
        applyStimulus("post_rst", 16'h0001 << OP_LOAD, EN_A, 8'h3C, 2);

        // Enables already held when reset releases execute exactly once.
        @(negedge clk);
        reset_n = 1'b0;
        op_en = 16'h0001 << OP_LOAD;
        {enable_A, enable_B, enable_Y} = EN_A;
        sw_data = 8'h5C;
        @(negedge clk);
        reset_n = 1'b1;
        done_pulses = 0;
        first_done = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_pulses++;
                if (first_done == 0) first_done = cyc;
            end
            if (cyc == 4) clearInputs();
        end
        model_reset();
        model_exec(OP_LOAD, 8'h5C);
        checkOutput("held_release.done_count", 32'(done_pulses), 32'd1);
        checkOutput("held_release.done_latency", 32'(first_done), 32'd2);
        checkState("held_release");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
